// File: rtl/imem_loader.sv
// imem_loader: boot loader and write-side master for the instruction memory DATA port.
// It receives a framed byte stream, assembles little-endian 32-bit words and writes them
// from word 0 up. It then reads the image back through the same port, checks it against
// the stream checksum, and releases the core once a verified image is in place.
//
// Frame: SYNC, LEN_LO, LEN_HI (N words), N*4 data bytes (LSB first), CSUM (XOR of data).
//
// Ports:
//   CLK, RESET_N         clock, asynchronous active-low reset
//   RX_DATA/VALID/READY  byte stream in (valid/ready handshake)
//   DATA_A/WE/WD/RD      imem DATA port (RD registered, valid one cycle after A)
//   CPU_HOLD             hold core in reset while an image is loading or failed
//   BUSY                 frame in progress
//   DONE                 one-cycle pulse: image written and verified
//   ERROR, ERR_CODE      sticky error: 0 timeout, 1 length, 2 rx checksum, 3 readback
module imem_loader #(
    parameter int unsigned AW      = 13,
    parameter logic [7:0]  SYNC    = 8'hA5,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    output logic        RX_READY,
    output logic [29:0] DATA_A,
    output logic        DATA_WE,
    output logic [31:0] DATA_WD,
    input  logic [31:0] DATA_RD,
    output logic        CPU_HOLD,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERROR,
    output logic [1:0]  ERR_CODE
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    // Word counter is one bit wider than the address so N = 2**AW needs no wrap.
    localparam int unsigned CW = AW + 1;
    localparam logic [16:0] MAX_WORDS = 17'(1) << AW;

    typedef enum logic [3:0] {
        StIdle, StLen0, StLen1, StData, StWrite, StCsum, StVerify, StCheck, StErr
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      len_lo_q, len_lo_d;
    logic [CW-1:0]   len_q, len_d;
    logic [CW-1:0]   idx_q, idx_d;
    logic [1:0]      bcnt_q, bcnt_d;
    logic [23:0]     asm_q, asm_d;
    logic [31:0]     wd_q, wd_d;
    logic [7:0]      rx_sum_q, rx_sum_d;
    logic [7:0]      rd_sum_q, rd_sum_d;
    logic            rd_pend_q, rd_pend_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            hold_q, hold_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [1:0]      code_q, code_d;
    // Keeps RX_READY low while in reset and for the first cycle after it.
    logic            live_q;

    logic            accept;
    logic            timed;
    logic            issue;
    logic [15:0]     len_n;

    assign accept = RX_VALID && RX_READY;
    assign timed  = state_q inside {StLen0, StLen1, StData, StCsum};
    assign issue  = (state_q == StVerify) && (idx_q != len_q);
    assign len_n  = {RX_DATA, len_lo_q};

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath next values
    always_comb begin
        state_d   = state_q;
        len_lo_d  = len_lo_q;
        len_d     = len_q;
        idx_d     = idx_q;
        bcnt_d    = bcnt_q;
        asm_d     = asm_q;
        wd_d      = wd_q;
        rx_sum_d  = rx_sum_q;
        rd_sum_d  = rd_sum_q;
        rd_pend_d = 1'b0;
        tmo_d     = '0;
        hold_d    = hold_q;
        done_d    = 1'b0;
        err_d     = err_q;
        code_d    = code_q;

        case (state_q)
            StIdle, StErr: begin
                if (accept && RX_DATA == SYNC) begin
                    state_d  = StLen0;
                    hold_d   = 1'b1;
                    err_d    = 1'b0;
                    code_d   = 2'd0;
                    rx_sum_d = '0;
                    idx_d    = '0;
                    bcnt_d   = '0;
                end
            end
            StLen0: begin
                if (accept) begin
                    len_lo_d = RX_DATA;
                    state_d  = StLen1;
                end
            end
            StLen1: begin
                if (accept) begin
                    if ({1'b0, len_n} > MAX_WORDS) begin
                        state_d = StErr;
                        err_d   = 1'b1;
                        code_d  = 2'd1;
                    end else begin
                        len_d   = CW'(len_n);
                        state_d = (len_n == 16'd0) ? StCsum : StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    rx_sum_d = rx_sum_q ^ RX_DATA;
                    bcnt_d   = bcnt_q + 2'd1;
                    // Bytes shift in from the top so byte 0 ends up in the low lane.
                    asm_d    = {RX_DATA, asm_q[23:8]};
                    if (bcnt_q == 2'd3) begin
                        wd_d    = {RX_DATA, asm_q};
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                idx_d   = idx_q + CW'(1);
                state_d = (idx_q + CW'(1) == len_q) ? StCsum : StData;
            end
            StCsum: begin
                if (accept) begin
                    if (RX_DATA != rx_sum_q) begin
                        state_d = StErr;
                        err_d   = 1'b1;
                        code_d  = 2'd2;
                    end else begin
                        state_d  = StVerify;
                        idx_d    = '0;
                        rd_sum_d = '0;
                    end
                end
            end
            StVerify: begin
                if (rd_pend_q) begin
                    rd_sum_d = rd_sum_q ^ DATA_RD[7:0] ^ DATA_RD[15:8] ^ DATA_RD[23:16]
                               ^ DATA_RD[31:24];
                end
                if (issue) begin
                    idx_d     = idx_q + CW'(1);
                    rd_pend_d = 1'b1;
                end else begin
                    // Drain cycle: the last read word is folded in above.
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (rd_sum_q != rx_sum_q) begin
                    state_d = StErr;
                    err_d   = 1'b1;
                    code_d  = 2'd3;
                end else begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    hold_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (timed && !accept) begin
            if (tmo_q == TW'(TIMEOUT - 1)) begin
                state_d = StErr;
                err_d   = 1'b1;
                code_d  = 2'd0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            len_lo_q  <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            bcnt_q    <= '0;
            asm_q     <= '0;
            wd_q      <= '0;
            rx_sum_q  <= '0;
            rd_sum_q  <= '0;
            rd_pend_q <= 1'b0;
            tmo_q     <= '0;
            hold_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= 2'd0;
            live_q    <= 1'b0;
        end else begin
            len_lo_q  <= len_lo_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            bcnt_q    <= bcnt_d;
            asm_q     <= asm_d;
            wd_q      <= wd_d;
            rx_sum_q  <= rx_sum_d;
            rd_sum_q  <= rd_sum_d;
            rd_pend_q <= rd_pend_d;
            tmo_q     <= tmo_d;
            hold_q    <= hold_d;
            done_q    <= done_d;
            err_q     <= err_d;
            code_q    <= code_d;
            live_q    <= 1'b1;
        end
    end

    // Outputs
    always_comb begin
        RX_READY = 1'b0;
        DATA_WE  = 1'b0;
        DATA_A   = '0;
        BUSY     = 1'b0;
        DATA_WD  = wd_q;
        CPU_HOLD = hold_q;
        DONE     = done_q;
        ERROR    = err_q;
        ERR_CODE = code_q;
        case (state_q)
            StIdle, StErr: RX_READY = live_q;
            StLen0, StLen1, StData, StCsum: begin
                RX_READY = live_q;
                BUSY     = 1'b1;
            end
            StWrite: begin
                DATA_WE = 1'b1;
                DATA_A  = 30'(idx_q[AW-1:0]);
                BUSY    = 1'b1;
            end
            StVerify: begin
                BUSY = 1'b1;
                if (issue) begin
                    DATA_A = 30'(idx_q[AW-1:0]);
                end
            end
            StCheck: BUSY = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int unsigned AW      = 5;
    localparam int unsigned TIMEOUT = 200;
    localparam int          EV_DONE = 4;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [7:0]  RX_DATA;
    logic        RX_VALID;
    logic        RX_READY;
    logic [29:0] DATA_A;
    logic        DATA_WE;
    logic [31:0] DATA_WD;
    logic [31:0] DATA_RD;
    logic        CPU_HOLD;
    logic        BUSY;
    logic        DONE;
    logic        ERROR;
    logic [1:0]  ERR_CODE;

    imem_loader #(.AW(AW), .SYNC(8'hA5), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
        .RX_READY(RX_READY), .DATA_A(DATA_A), .DATA_WE(DATA_WE), .DATA_WD(DATA_WD),
        .DATA_RD(DATA_RD), .CPU_HOLD(CPU_HOLD), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR),
        .ERR_CODE(ERR_CODE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [29:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_wr[$];
    int          exp_evt[$];
    logic [31:0] frame_words[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          corrupt  = 1'b0;

    // imem model: registered read, optional corruption of word 1 on readback
    logic [31:0] mem [0:(1<<AW)-1];
    always @(posedge CLK) begin
        if (DATA_WE) mem[DATA_A[AW-1:0]] <= DATA_WD;
        DATA_RD <= mem[DATA_A[AW-1:0]] ^ ((corrupt && DATA_A == 30'd1) ? 32'h100 : 32'h0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes or reports an outcome.
    logic err_prev  = 1'b0;
    logic done_prev = 1'b0;
    always @(negedge CLK) begin
        if (RESET_N) begin
            if (DATA_WE) begin
                check("we_rx_ready_low", RX_READY, 0);
                if (exp_wr.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("wr_addr", DATA_A, e.a);
                    check("wr_data", DATA_WD, e.d);
                end
            end
            if (DONE) begin
                check("done_single_pulse", done_prev, 0);
                if (exp_evt.size() == 0) check("unexpected_done", 1, 0);
                else check("outcome_done", EV_DONE, exp_evt.pop_front());
                check("done_status", {CPU_HOLD, BUSY, ERROR}, 3'b000);
            end
            if (ERROR && !err_prev) begin
                if (exp_evt.size() == 0) check("unexpected_error", 1, 0);
                else check("outcome_err_code", ERR_CODE, exp_evt.pop_front());
                check("err_status", {CPU_HOLD, BUSY, RX_READY}, 3'b101);
            end
        end
        err_prev  = ERROR;
        done_prev = DONE;
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        ok       = 1'b0;
        RX_DATA  = b;
        RX_VALID = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge CLK);
            if (RX_READY) begin
                ok = 1'b1;
                break;
            end
        end
        check("rx_accept", ok, 1);
        @(posedge CLK);
        #1;
        if (gap > 0) begin
            RX_VALID = 1'b0;
            repeat (gap) @(posedge CLK);
            #1;
        end
    endtask

    // Reference model: expected writes are the frame words themselves, the checksum
    // is the XOR of every byte sent, and the outcome follows from length/checksum/readback.
    task automatic send_frame(input int n, input logic [7:0] delta, input bit bad_rd,
                              input int gap_max);
        logic [7:0]  sum;
        logic [15:0] len16;
        wr_t         w;
        sum     = 8'h00;
        len16   = 16'(n);
        corrupt = bad_rd;
        if (n > (1 << AW)) begin
            exp_evt.push_back(1);
        end else begin
            for (int i = 0; i < n; i++) begin
                w.a = 30'(i);
                w.d = frame_words[i];
                exp_wr.push_back(w);
                for (int k = 0; k < 4; k++) sum ^= 8'((frame_words[i] >> (8 * k)) & 32'hFF);
            end
            if (delta != 8'h00) exp_evt.push_back(2);
            else if (bad_rd && n > 1) exp_evt.push_back(3);
            else exp_evt.push_back(EV_DONE);
        end
        send_byte(8'hA5, $urandom_range(gap_max, 0));
        check("sync_hold_busy", {CPU_HOLD, BUSY}, 2'b11);
        send_byte(len16 % 256, $urandom_range(gap_max, 0));
        send_byte(len16 / 256, $urandom_range(gap_max, 0));
        if (n <= (1 << AW)) begin
            for (int i = 0; i < n; i++)
                for (int k = 0; k < 4; k++)
                    send_byte(8'((frame_words[i] >> (8 * k)) & 32'hFF),
                              $urandom_range(gap_max, 0));
            send_byte(sum ^ delta, 0);
        end
        RX_VALID = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int i;
        i = 0;
        while ((exp_evt.size() != 0 || exp_wr.size() != 0) && i < 5000) begin
            @(posedge CLK);
            i++;
        end
        check({"drain_", name}, exp_evt.size() + exp_wr.size(), 0);
        exp_evt.delete();
        exp_wr.delete();
        repeat (3) @(posedge CLK);
        #1;
        corrupt = 1'b0;
    endtask

    task automatic rand_words(input int n);
        frame_words.delete();
        for (int i = 0; i < n; i++) frame_words.push_back($urandom);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_data"}, {DATA_A, DATA_WD}, 0);
        check({name, "_ctrl"}, {RX_READY, DATA_WE, CPU_HOLD, BUSY, DONE, ERROR, ERR_CODE}, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RESET_N  = 1'b0;
        RX_VALID = 1'b0;
        RX_DATA  = 8'h00;
        #23;
        check_reset_outputs("reset");
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (2) @(posedge CLK);
        #1;

        // Fixed two-word frame
        frame_words = '{32'h44332211, 32'h88776655};
        send_frame(2, 8'h00, 1'b0, 0);
        wait_drain("fixed");

        // Bad checksum, then a good retry clears the error
        send_frame(2, 8'h01, 1'b0, 1);
        wait_drain("bad_csum");
        send_frame(2, 8'h00, 1'b0, 1);
        wait_drain("retry");

        // Readback corruption of word 1
        rand_words(3);
        send_frame(3, 8'h00, 1'b1, 0);
        wait_drain("readback");

        // Oversized length, empty image, largest legal image
        send_frame((1 << AW) + 1, 8'h00, 1'b0, 0);
        wait_drain("too_long");
        frame_words.delete();
        send_frame(0, 8'h00, 1'b0, 0);
        wait_drain("empty");
        rand_words(1 << AW);
        send_frame(1 << AW, 8'h00, 1'b0, 0);
        wait_drain("max_len");

        // Timeout after the third data byte
        exp_evt.push_back(0);
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'h56, 0);
        RX_VALID = 1'b0;
        repeat (TIMEOUT + 20) @(posedge CLK);
        wait_drain("timeout");

        // Reset mid-DATA, then a clean frame
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h9A, 0);
        send_byte(8'hBC, 0);
        RX_VALID = 1'b0;
        RESET_N  = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        rand_words(2);
        send_frame(2, 8'h00, 1'b0, 2);
        wait_drain("after_reset");

        // Back-to-back bytes with RX_VALID held high
        rand_words(4);
        send_frame(4, 8'h00, 1'b0, 0);
        wait_drain("streamed");

        // Random frames
        for (int f = 0; f < 8; f++) begin
            int n;
            n = $urandom_range(8, 1);
            rand_words(n);
            send_frame(n, 8'h00, 1'b0, 3);
            wait_drain("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
